// File: rtl/rs_dispatch_unit.sv
// rtl/rs_dispatch_unit.sv - in-order dispatch FIFO feeding a bank of reservation stations
//
// Buffers decoded instructions in a small FIFO and writes the head entry into
// one reservation station per cycle. A station qualifies when its type code
// matches the head type and it is not full; qualifying stations are chosen
// round-robin starting at rr_ptr.
//
// Ports:
//   clock_i        clock
//   reset_i        asynchronous reset, active-low
//   enable_i       decode presents a valid instruction
//   flush_i        synchronous flush of all buffered instructions
//   stall_i        global stall; blocks dispatch, enqueue still allowed
//   funcUnitType_i functional-unit type of the incoming instruction
//   inst_i         incoming instruction bundle
//   rsFull_i       per-station full flags (bit k = station k)
//   full_o         FIFO full; decode must hold
//   empty_o        FIFO empty
//   enable_o       one-hot registered write strobe to station k
//   payload_o      registered bundle broadcast to all stations
//   unroutable_o   registered: head type matches no station
module rs_dispatch_unit #(
  parameter int numStations      = 4,
  parameter int funcUnitCodeSize = 3,
  parameter logic [numStations*funcUnitCodeSize-1:0] stationTypes = {3'd0, 3'd0, 3'd1, 3'd2},
  parameter int fifoIdxBits      = 2,
  parameter int payloadWidth     = 305
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        flush_i,
  input  logic                        stall_i,
  input  logic [funcUnitCodeSize-1:0] funcUnitType_i,
  input  logic [payloadWidth-1:0]     inst_i,
  input  logic [numStations-1:0]      rsFull_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [numStations-1:0]      enable_o,
  output logic [payloadWidth-1:0]     payload_o,
  output logic                        unroutable_o
);

  localparam int DEPTH = 2 ** fifoIdxBits;
  localparam int CNT_W = fifoIdxBits + 1;
  localparam int ENT_W = funcUnitCodeSize + payloadWidth;
  localparam int RR_W  = (numStations > 1) ? $clog2(numStations) : 1;

  // Each entry stores {type, bundle}; type lives in the MSBs.
  logic [ENT_W-1:0]       mem [DEPTH];
  logic [fifoIdxBits-1:0] head_ptr;
  logic [fifoIdxBits-1:0] tail_ptr;
  logic [CNT_W-1:0]       count;
  logic [RR_W-1:0]        rr_ptr;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [ENT_W-1:0]            head_entry;
  logic [funcUnitCodeSize-1:0] head_type;
  logic [numStations-1:0]      cand;
  logic                        match_any;
  logic                        found;
  logic [RR_W-1:0]             sel;
  logic [numStations-1:0]      sel_onehot;
  logic                        push;
  logic                        pop;

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;

  assign head_entry = mem[head_ptr];
  assign head_type  = head_entry[ENT_W-1 -: funcUnitCodeSize];

  // Station 0's type code sits in the MSBs of stationTypes.
  always_comb begin
    cand      = '0;
    match_any = 1'b0;
    for (int k = 0; k < numStations; k++) begin
      if (stationTypes[(numStations-1-k)*funcUnitCodeSize +: funcUnitCodeSize] == head_type) begin
        match_any = 1'b1;
        cand[k]   = !fifo_empty && !rsFull_i[k];
      end
    end
  end

  // Round-robin pick: first candidate at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < numStations; i++) begin
      if (!found && cand[(int'(rr_ptr) + i) % numStations]) begin
        found = 1'b1;
        sel   = RR_W'((int'(rr_ptr) + i) % numStations);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < numStations; k++) begin
      sel_onehot[k] = (int'(sel) == k);
    end
  end

  // A full FIFO refuses input even if the head leaves this same cycle.
  assign push = enable_i && !fifo_full && !flush_i;
  assign pop  = found && !stall_i && !flush_i;

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[tail_ptr] <= {funcUnitType_i, inst_i};
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count        <= '0;
      head_ptr     <= '0;
      tail_ptr     <= '0;
      rr_ptr       <= '0;
      enable_o     <= '0;
      payload_o    <= '0;
      unroutable_o <= 1'b0;
    end else if (flush_i) begin
      // rr_ptr and payload_o deliberately survive a flush.
      count        <= '0;
      head_ptr     <= '0;
      tail_ptr     <= '0;
      enable_o     <= '0;
      unroutable_o <= 1'b0;
    end else begin
      unroutable_o <= !fifo_empty && !match_any;
      if (push) begin
        tail_ptr <= tail_ptr + fifoIdxBits'(1);
      end
      if (pop) begin
        head_ptr  <= head_ptr + fifoIdxBits'(1);
        rr_ptr    <= RR_W'((int'(sel) + 1) % numStations);
        enable_o  <= sel_onehot;
        payload_o <= head_entry[payloadWidth-1:0];
      end else begin
        enable_o <= '0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_dispatch_unit.sv
// tb/tb_rs_dispatch_unit.sv - directed self-checking bench for rs_dispatch_unit
module tb_rs_dispatch_unit;

  logic         clock_i;
  logic         reset_i;
  logic         enable_i;
  logic         flush_i;
  logic         stall_i;
  logic [2:0]   funcUnitType_i;
  logic [304:0] inst_i;
  logic [3:0]   rsFull_i;
  logic         full_o;
  logic         empty_o;
  logic [3:0]   enable_o;
  logic [304:0] payload_o;
  logic         unroutable_o;

  int total;
  int bad;

  rs_dispatch_unit dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .funcUnitType_i (funcUnitType_i),
    .inst_i         (inst_i),
    .rsFull_i       (rsFull_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .enable_o       (enable_o),
    .payload_o      (payload_o),
    .unroutable_o   (unroutable_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] typ, input logic [31:0] val);
    enable_i       = en;
    funcUnitType_i = typ;
    inst_i         = 305'(val);
  endtask

  initial begin
    logic [3:0] seq [4];
    total = 0;
    bad   = 0;
    reset_i = 1'b0;
    flush_i = 1'b0;
    stall_i = 1'b0;
    rsFull_i = 4'b0000;
    drive(1'b0, 3'd0, 32'h0);
    #12;
    check("rst_en",    320'(enable_o), 320'(4'b0000));
    check("rst_pay",   320'(payload_o), 320'(0));
    check("rst_full",  320'(full_o), 320'(0));
    check("rst_empty", 320'(empty_o), 320'(1));
    check("rst_unr",   320'(unroutable_o), 320'(0));
    reset_i = 1'b1;
    step();

    // Single type-1 push lands on station 2; rr_ptr becomes 3.
    drive(1'b1, 3'd1, 32'hA5);
    step();
    drive(1'b0, 3'd0, 32'h0);
    check("t1_en0", 320'(enable_o), 320'(4'b0000));
    step();
    check("t1_en1", 320'(enable_o), 320'(4'b0100));
    check("t1_pay", 320'(payload_o), 320'(32'hA5));
    check("t1_empty", 320'(empty_o), 320'(1));
    step();
    check("t1_en2", 320'(enable_o), 320'(4'b0000));
    check("t1_hold", 320'(payload_o), 320'(32'hA5));

    // Four type-0 back-to-back: rr from 3 -> 0,1,0,1.
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 32'h20 + i);
      step();
      if (i == 0) check("t2_lat", 320'(enable_o), 320'(4'b0000));
      else begin
        check("t2_en", 320'(enable_o), 320'(seq[i-1]));
        check("t2_pay", 320'(payload_o), 320'(32'h20 + i - 1));
      end
    end
    drive(1'b0, 3'd0, 32'h0);
    step();
    check("t2_en_last", 320'(enable_o), 320'(seq[3]));

    // Station 0 full: everything goes to station 1.
    rsFull_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 32'h30 + i);
      step();
      if (i > 0) check("t2b_en", 320'(enable_o), 320'(4'b0010));
    end
    drive(1'b0, 3'd0, 32'h0);
    step();
    check("t2b_en_last", 320'(enable_o), 320'(4'b0010));
    step();
    check("t2b_idle", 320'(enable_o), 320'(4'b0000));

    // Fill to full with all stations full; fifth push refused.
    rsFull_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd0, 32'h10 + i);
      step();
      check("t3_en_blk", 320'(enable_o), 320'(4'b0000));
      if (i == 3) check("t3_full4", 320'(full_o), 320'(1));
    end
    drive(1'b0, 3'd0, 32'h0);
    check("t3_full5", 320'(full_o), 320'(1));
    rsFull_i = 4'b0000;
    // rr_ptr is 2 here: stations 0,1,0,1 in turn.
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_en", 320'(enable_o), 320'(seq[i]));
      check("t3_pay", 320'(payload_o), 320'(32'h10 + i));
      if (i == 0) check("t3_full_drop", 320'(full_o), 320'(0));
    end
    step();
    check("t3_done_en", 320'(enable_o), 320'(4'b0000));
    check("t3_done_empty", 320'(empty_o), 320'(1));

    // Stall 3 cycles while enqueueing two type-2 instructions.
    stall_i = 1'b1;
    drive(1'b1, 3'd2, 32'h41);
    step();
    check("t4_st0", 320'(enable_o), 320'(4'b0000));
    drive(1'b1, 3'd2, 32'h42);
    step();
    check("t4_st1", 320'(enable_o), 320'(4'b0000));
    drive(1'b0, 3'd0, 32'h0);
    step();
    check("t4_st2", 320'(enable_o), 320'(4'b0000));
    check("t4_empty", 320'(empty_o), 320'(0));
    stall_i = 1'b0;
    step();
    check("t4_en0", 320'(enable_o), 320'(4'b1000));
    check("t4_pay0", 320'(payload_o), 320'(32'h41));
    step();
    check("t4_en1", 320'(enable_o), 320'(4'b1000));
    check("t4_pay1", 320'(payload_o), 320'(32'h42));
    step();
    check("t4_idle", 320'(enable_o), 320'(4'b0000));

    // Unmapped head blocks younger entries until flush.
    drive(1'b1, 3'd3, 32'h33);
    step();
    drive(1'b1, 3'd0, 32'h50);
    step();
    drive(1'b1, 3'd0, 32'h51);
    step();
    drive(1'b0, 3'd0, 32'h0);
    check("t5_unr", 320'(unroutable_o), 320'(1));
    check("t5_en", 320'(enable_o), 320'(4'b0000));
    step();
    check("t5_en2", 320'(enable_o), 320'(4'b0000));
    check("t5_unr2", 320'(unroutable_o), 320'(1));
    flush_i = 1'b1;
    drive(1'b1, 3'd0, 32'h66);
    step();
    flush_i = 1'b0;
    drive(1'b0, 3'd0, 32'h0);
    check("t5_fl_empty", 320'(empty_o), 320'(1));
    check("t5_fl_unr", 320'(unroutable_o), 320'(0));
    check("t5_fl_en", 320'(enable_o), 320'(4'b0000));
    step();
    check("t5_drop_en", 320'(enable_o), 320'(4'b0000));
    check("t5_drop_empty", 320'(empty_o), 320'(1));

    // Async reset mid-dispatch; rr_ptr is 0 (kept across flush).
    drive(1'b1, 3'd0, 32'h70);
    step();
    drive(1'b1, 3'd0, 32'h71);
    step();
    drive(1'b0, 3'd0, 32'h0);
    check("t6_en", 320'(enable_o), 320'(4'b0001));
    check("t6_nonempty", 320'(empty_o), 320'(0));
    #2;
    reset_i = 1'b0;
    #1;
    check("t6_async_en", 320'(enable_o), 320'(4'b0000));
    check("t6_async_empty", 320'(empty_o), 320'(1));
    step();
    reset_i = 1'b1;
    step();
    check("t6_post_en", 320'(enable_o), 320'(4'b0000));
    check("t6_post_empty", 320'(empty_o), 320'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_dispatch_unit.md
Name: rs_dispatch_unit

Overview:
Transmit side of the reservation-station allocation interface. Buffers decoded instructions from the decode stage in a small in-order FIFO and drives each head instruction into one of numStations reservation stations. A station qualifies only if its functional-unit type matches the instruction and its isFull_o (seen here as rsFull_i) is low; among qualifying stations the choice is round-robin. Sits between the decoders and the reservation station bank.

Parameters:
numStations, 4, number of reservation stations driven (max 8)
funcUnitCodeSize, 3, width of the functional-unit type code
stationTypes, {3'd0,3'd0,3'd1,3'd2}, packed type code per station; station 0 in the MSBs
fifoIdxBits, 2, log2 FIFO depth (depth 4)
payloadWidth, 305, packed instruction bundle: format, opcode, address, majID, minID, is64Bit, pid, tid, rw patterns, isReg bits, body

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous reset, active-low
enable_i  in  1  decode presents a valid instruction
flush_i  in  1  synchronous flush of all buffered instructions
stall_i  in  1  global stall; no dispatch while high, enqueue still allowed
funcUnitType_i  in  funcUnitCodeSize  functional-unit type of the incoming instruction
inst_i  in  payloadWidth  incoming instruction bundle
rsFull_i  in  numStations  per-station full flags; bit k belongs to station k
full_o  out  1  FIFO full; decode must hold its instruction
empty_o  out  1  FIFO empty
enable_o  out  numStations  one-hot write strobe to station k
payload_o  out  payloadWidth  bundle broadcast to all stations
unroutable_o  out  1  head type matches no station in stationTypes

Behaviour:
- Reset (async, reset_i=0): FIFO count, head and tail pointers = 0; rrPtr = 0. Outputs: enable_o=0, payload_o=0, full_o=0, empty_o=1, unroutable_o=0.
- full_o = (count == 2**fifoIdxBits). empty_o = (count == 0). Both are decoded from the registered count.
- Enqueue occurs when enable_i && !full_o && !flush_i. The push writes {funcUnitType_i, inst_i} at the tail; tail wraps modulo depth.
- When full, input is refused even if a pop happens in the same cycle.
- Dispatch candidates: cand[k] = !empty && (stationTypes[k] == head type) && !rsFull_i[k].
- Dispatch occurs when |cand && !stall_i && !flush_i. The selected station sel is the first k with cand[k], scanning rrPtr, rrPtr+1, … modulo numStations.
- On dispatch, at the next edge:
  - enable_o = one-hot(sel) and payload_o = head bundle;
  - head advances (wraps modulo depth);
  - rrPtr = (sel+1) mod numStations.
- On any cycle without dispatch, enable_o = 0 at the next edge and payload_o holds its last value.
- Only one instruction is dispatched per cycle. Order is strictly in-order: a blocked head blocks all younger entries.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Latency: an instruction presented at edge t into an empty FIFO can assert enable_o from edge t+1 onward, i.e. visible in the cycle after next. There is no enqueue-to-dispatch bypass.
- unroutable_o is registered. It is 1 while non-empty and the head type equals no stationTypes entry. Such a head is never dispatched and stays stuck until flush or reset.
- Priority: reset > flush > stall. flush_i clears count and pointers and forces enable_o=0 and unroutable_o=0 next edge. An input asserted in the flush cycle is dropped. rrPtr is kept across flush.
- Reset asserted mid-dispatch clears enable_o immediately (async). No partial write strobe survives.
- All rsFull_i bits of matching stations high: head holds, enable_o=0, no rrPtr change.

Test Plan:
- Reset then single push, type 1, inst=0x…A5, all rsFull_i=0 -> enable_o=4'b0100 exactly one cycle, payload_o=0x…A5 two cycles after push, empty_o back to 1.
- Four type-0 instructions back-to-back, no stall -> enable_o sequence 0001,0010,0001,0010 (round-robin over stations 0/1). With rsFull_i[0]=1 throughout -> all go to 0010.
- Five pushes with rsFull_i=4'b1111 -> full_o=1 after the 4th, 5th refused. Release rsFull_i -> four dispatches in order, full_o drops the cycle after the first pop.
- stall_i=1 for 3 cycles with 2 queued type-2 instructions -> enable_o=0 throughout, pushes still accepted. Release -> 1000 on consecutive cycles.
- Head type 3 (unmapped) -> unroutable_o=1, nothing dispatched, younger type-0 entries blocked. flush_i -> count 0, unroutable_o=0, empty_o=1.
- reset_i pulled low asynchronously while enable_o=0001 -> enable_o=0 before the next edge, FIFO empty after release.
